// File: rtl/ptmch_multi.sv
// ptmch_multi: multi-channel serial pattern matcher, single clock domain.
//   CLK200M   : sole clock
//   RESET     : synchronous, active-high
//   SPI_CS/SPI_CLK/SPI_MOSI : write-only config link (mode 0, MSB first),
//               oversampled; frame = {EN,rsv[2:0],CH[3:0], pat, mask}
//   PTCLK/PTDAT : async serial stream shifted into a PAT_W-bit window
//   TRG_PLS   : per-channel trigger pulses, PLS_LEN cycles, retriggerable
//   TRG_ANY   : OR of TRG_PLS, registered in the same cycle
//   CFG_ERR   : one-cycle pulse when an SPI frame is rejected

// Per-channel config registers, match compare and pulse stretcher.
//   eval    : window was shifted last cycle and is full
//   wr*     : commit of a new en/pat/mask for this channel
//   pls_d   : next value of the pulse (feeds the shared TRG_ANY flop)
//   pls_q   : registered pulse output
module ptmch_ch #(
  parameter int PAT_W   = 32,
  parameter int PLS_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             eval,
  input  logic [PAT_W-1:0] window,
  input  logic             wr,
  input  logic             wr_en,
  input  logic [PAT_W-1:0] wr_pat,
  input  logic [PAT_W-1:0] wr_mask,
  output logic             pls_d,
  output logic             pls_q
);
  localparam int CNT_W = $clog2(PLS_LEN + 1);

  logic             en_q, en_d;
  logic [PAT_W-1:0] pat_q, pat_d, mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  always_comb begin
    en_d   = en_q;
    pat_d  = pat_q;
    mask_d = mask_q;
    if (wr) begin
      en_d   = wr_en;
      pat_d  = wr_pat;
      mask_d = wr_mask;
    end
    // compare uses the registered config, so a same-cycle commit only
    // affects later evaluations
    hit = eval && en_q && (((window ^ pat_q) & mask_q) == '0);
    // a hit reloads the counter, stretching an active pulse without a gap;
    // disabling the channel leaves a running count alone
    if (hit)               cnt_d = CNT_W'(PLS_LEN);
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
    else                   cnt_d = '0;
    pls_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      pat_q  <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
      pls_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      pat_q  <= pat_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      pls_q  <= pls_d;
    end
  end
endmodule

module ptmch_multi #(
  parameter int NUM_CH   = 4,
  parameter int PAT_W    = 32,
  parameter int PLS_LEN  = 8,
  parameter int SYNC_STG = 2
) (
  input  logic              CLK200M,
  input  logic              RESET,
  input  logic              SPI_CS,
  input  logic              SPI_CLK,
  input  logic              SPI_MOSI,
  input  logic              PTCLK,
  input  logic              PTDAT,
  output logic [NUM_CH-1:0] TRG_PLS,
  output logic              TRG_ANY,
  output logic              CFG_ERR
);
  localparam int FRAME_W = 8 + 2 * PAT_W;
  localparam int BC_W    = $clog2(FRAME_W + 2);
  localparam int FL_W    = $clog2(PAT_W + 1);

  // ---------------- input synchronizers ----------------
  // bit order: {cs, sclk, mosi, ptclk, ptdat}; data and its clock share the
  // same stage so they stay aligned. The chain is not reset so that a high
  // level on a clock input never looks like an edge when reset releases.
  logic [4:0]                async_in;
  logic [SYNC_STG-1:0][4:0]  sync_q, sync_d;
  logic [2:0]                dly_q, dly_d;   // {cs, sclk, ptclk} delayed
  logic [4:0]                s;
  logic cs_s, sclk_s, mosi_s, ptclk_s, ptdat_s;
  logic pt_rise, sclk_rise, cs_rise, cs_fall;

  assign async_in = {SPI_CS, SPI_CLK, SPI_MOSI, PTCLK, PTDAT};
  assign s        = sync_q[SYNC_STG-1];
  assign {cs_s, sclk_s, mosi_s, ptclk_s, ptdat_s} = s;

  always_comb begin
    sync_d = {sync_q[SYNC_STG-2:0], async_in};
    dly_d  = {cs_s, sclk_s, ptclk_s};
  end

  always_ff @(posedge CLK200M) begin
    sync_q <= sync_d;
    dly_q  <= dly_d;
  end

  assign pt_rise   = ptclk_s & ~dly_q[0];
  assign sclk_rise = sclk_s  & ~dly_q[1];
  assign cs_rise   = cs_s    & ~dly_q[2];
  assign cs_fall   = ~cs_s   &  dly_q[2];

  // ---------------- stream window ----------------
  logic [PAT_W-1:0] window_q, window_d;
  logic [FL_W-1:0]  fill_q, fill_d;
  logic             eval_q, eval_d;     // window shifted last cycle
  logic             win_full;

  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    eval_d   = pt_rise;
    if (pt_rise) begin
      window_d = {window_q[PAT_W-2:0], ptdat_s};
      if (fill_q != FL_W'(PAT_W)) fill_d = fill_q + 1'b1;
    end
  end

  assign win_full = (fill_q == FL_W'(PAT_W));

  // ---------------- SPI config frame ----------------
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]    bcnt_q, bcnt_d;
  logic               cfg_err_q, cfg_err_d;
  logic               commit, frame_ok;
  logic [7:0]         hdr;
  logic [PAT_W-1:0]   frm_pat, frm_mask;

  assign hdr      = shreg_q[FRAME_W-1 -: 8];
  assign frm_pat  = shreg_q[2*PAT_W-1 -: PAT_W];
  assign frm_mask = shreg_q[PAT_W-1:0];
  assign frame_ok = (bcnt_q == BC_W'(FRAME_W)) &&
                    ({1'b0, hdr[3:0]} < 5'(NUM_CH)) &&
                    (hdr[6:4] == 3'b000);

  always_comb begin
    shreg_d   = shreg_q;
    bcnt_d    = bcnt_q;
    commit    = 1'b0;
    cfg_err_d = 1'b0;
    if (cs_fall) begin
      shreg_d = '0;
      bcnt_d  = '0;
    end else if (sclk_rise && !cs_s) begin
      shreg_d = {shreg_q[FRAME_W-2:0], mosi_s};
      // saturating one past a full frame keeps over-long frames rejectable
      if (bcnt_q != BC_W'(FRAME_W + 1)) bcnt_d = bcnt_q + 1'b1;
    end
    // an empty CS toggle is neither a commit nor an error
    if (cs_rise && (bcnt_q != '0)) begin
      if (frame_ok) commit    = 1'b1;
      else          cfg_err_d = 1'b1;
    end
  end

  // ---------------- channels ----------------
  logic [NUM_CH-1:0] pls_nxt;
  logic              trg_any_q, trg_any_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ptmch_ch #(.PAT_W(PAT_W), .PLS_LEN(PLS_LEN)) u_ch (
      .clk     (CLK200M),
      .rst     (RESET),
      .eval    (eval_q & win_full),
      .window  (window_q),
      .wr      (commit && (hdr[3:0] == 4'(g))),
      .wr_en   (hdr[7]),
      .wr_pat  (frm_pat),
      .wr_mask (frm_mask),
      .pls_d   (pls_nxt[g]),
      .pls_q   (TRG_PLS[g])
    );
  end

  assign trg_any_d = |pls_nxt;

  always_ff @(posedge CLK200M) begin
    if (RESET) begin
      window_q  <= '0;
      fill_q    <= '0;
      eval_q    <= 1'b0;
      shreg_q   <= '0;
      bcnt_q    <= '0;
      cfg_err_q <= 1'b0;
      trg_any_q <= 1'b0;
    end else begin
      window_q  <= window_d;
      fill_q    <= fill_d;
      eval_q    <= eval_d;
      shreg_q   <= shreg_d;
      bcnt_q    <= bcnt_d;
      cfg_err_q <= cfg_err_d;
      trg_any_q <= trg_any_d;
    end
  end

  assign TRG_ANY = trg_any_q;
  assign CFG_ERR = cfg_err_q;
endmodule

// File: tb/tb_ptmch_multi.sv
// Scoreboard bench for ptmch_multi. Stimulus tasks update an abstract model
// (window value, per-channel config with its effective cycle) and push the
// expected pulse starts / CFG_ERR cycles into queues; a negedge monitor pops
// them and compares the DUT outputs every cycle.
module tb_ptmch_multi;
  localparam int NUM_CH = 4, PAT_W = 32, PLS_LEN = 8, SYNC_STG = 2;
  localparam int FW = 8 + 2 * PAT_W;

  logic clk = 0, rst = 1, cs = 1, sck = 0, mosi = 0, ptclk = 0, ptdat = 0;
  logic [NUM_CH-1:0] trg;
  logic any_o, err_o;

  ptmch_multi #(.NUM_CH(NUM_CH), .PAT_W(PAT_W), .PLS_LEN(PLS_LEN), .SYNC_STG(SYNC_STG)) dut (
    .CLK200M(clk), .RESET(rst), .SPI_CS(cs), .SPI_CLK(sck), .SPI_MOSI(mosi),
    .PTCLK(ptclk), .PTDAT(ptdat), .TRG_PLS(trg), .TRG_ANY(any_o), .CFG_ERR(err_o));

  always #5 clk = ~clk;

  int cyc = 0, checks = 0, errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int ch; } hit_t;
  hit_t hitq[$];
  int   errq[$];
  int   until_c[NUM_CH] = '{default: 0};
  int   rst_at = -1;

  // abstract model state
  logic [PAT_W-1:0] m_win = '0;
  int               m_fill = 0;
  logic             en_old[NUM_CH] = '{default: 0}, en_new[NUM_CH] = '{default: 0};
  logic [PAT_W-1:0] pat_old[NUM_CH] = '{default: 0}, pat_new[NUM_CH] = '{default: 0};
  logic [PAT_W-1:0] msk_old[NUM_CH] = '{default: 0}, msk_new[NUM_CH] = '{default: 0};
  int               eff[NUM_CH] = '{default: 0};

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endfunction

  // shift edge sampled at drive cycle t: evaluation happens at t+SYNC_STG+1,
  // pulse visible from the next cycle
  function automatic void model_edge(logic b, int t);
    int x;
    logic e;
    logic [PAT_W-1:0] p, m;
    x = t + SYNC_STG + 1;
    m_win = {m_win[PAT_W-2:0], b};
    if (m_fill < PAT_W) m_fill++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (x >= eff[c]) begin e = en_new[c]; p = pat_new[c]; m = msk_new[c]; end
      else             begin e = en_old[c]; p = pat_old[c]; m = msk_old[c]; end
      if (e && m_fill == PAT_W && ((m_win ^ p) & m) == '0)
        hitq.push_back('{cyc: x + 1, ch: c});
    end
  endfunction

  // CS rise driven at cycle t
  function automatic void model_cs(logic [FW-1:0] fr, int n, int t);
    logic [7:0] h;
    int c;
    if (n == 0) return;
    h = fr[FW-1 -: 8];
    if (n == FW && h[3:0] < NUM_CH && h[6:4] == 3'b000) begin
      c = int'(h[3:0]);
      en_old[c] = en_new[c]; pat_old[c] = pat_new[c]; msk_old[c] = msk_new[c];
      en_new[c] = h[7]; pat_new[c] = fr[2*PAT_W-1 -: PAT_W]; msk_new[c] = fr[PAT_W-1:0];
      eff[c] = t + SYNC_STG + 1;
    end else
      errq.push_back(t + SYNC_STG + 1);
  endfunction

  function automatic logic [FW-1:0] mk_frame(logic en, logic [2:0] rsv, logic [3:0] ch,
                                             logic [PAT_W-1:0] pat, logic [PAT_W-1:0] msk);
    return {en, rsv, ch, pat, msk};
  endfunction

  // monitor
  always @(negedge clk) begin : mon
    logic [NUM_CH-1:0] ev;
    logic ee;
    hit_t h;
    if (cyc == rst_at) begin
      for (int c = 0; c < NUM_CH; c++) until_c[c] = 0;
      while (hitq.size() > 0 && hitq[$].cyc >= rst_at) void'(hitq.pop_back());
      while (errq.size() > 0 && errq[$] >= rst_at) void'(errq.pop_back());
    end
    while (hitq.size() > 0 && hitq[0].cyc <= cyc) begin
      h = hitq.pop_front();
      until_c[h.ch] = h.cyc + PLS_LEN;
    end
    ee = 1'b0;
    while (errq.size() > 0 && errq[0] <= cyc) begin
      if (errq[0] == cyc) ee = 1'b1;
      void'(errq.pop_front());
    end
    for (int c = 0; c < NUM_CH; c++) ev[c] = (cyc < until_c[c]);
    if (cyc >= 2) begin
      check("trg_pls", 32'(trg), 32'(ev));
      check("trg_any", 32'(any_o), 32'(|ev));
      check("cfg_err", 32'(err_o), 32'(ee));
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic pt_bit(input logic b);
    @(negedge clk) ptclk = 0; ptdat = b;
    @(negedge clk);
    @(negedge clk) ptclk = 1;
    model_edge(b, cyc);
    @(negedge clk);
  endtask

  task automatic pt_word(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) pt_bit(v[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_open();
    @(negedge clk) cs = 0;
    idle(2);
  endtask

  task automatic spi_bits(input logic [FW-1:0] fr, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk) sck = 0; mosi = fr[i];
      @(negedge clk);
      @(negedge clk) sck = 1;
      @(negedge clk);
    end
    @(negedge clk) sck = 0;
    @(negedge clk);
  endtask

  task automatic spi_close(input logic [FW-1:0] fr, input int n);
    @(negedge clk) cs = 1;
    model_cs(fr, n, cyc);
    idle(3);
  endtask

  task automatic spi_frame(input logic [FW-1:0] fr, input int n);
    spi_open();
    spi_bits(fr, n);
    spi_close(fr, n);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1;
    rst_at = cyc + 1;
    m_win = '0; m_fill = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      en_old[c] = 0; en_new[c] = 0; pat_old[c] = '0; pat_new[c] = '0;
      msk_old[c] = '0; msk_new[c] = '0; eff[c] = 0;
    end
    @(negedge clk) rst = 0;
    idle(3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] fr, fr_new;
    rst = 1;
    idle(4);
    rst = 0;
    idle(4);

    // ch0 exact match on full window
    spi_frame(mk_frame(1, 0, 0, 32'hA5A5A5A5, 32'hFFFFFFFF), FW);
    pt_word(32'hA5A5A5A5, 32);
    idle(14);

    // ch1 nibble-masked match
    spi_frame(mk_frame(1, 0, 1, 32'h000000F0, 32'h000000F0), FW);
    pt_word(32'h123456F7, 32);
    idle(14);

    // fill guard: matching data but fewer than PAT_W bits since reset
    do_reset();
    spi_frame(mk_frame(1, 0, 1, 32'h000000F0, 32'h000000F0), FW);
    pt_word(32'h000056F7, 16);
    idle(14);

    // ch2 retriggered every 8 cycles -> continuous pulse
    spi_frame(mk_frame(1, 0, 2, 32'h55555555, 32'hFFFFFFFF), FW);
    pt_word(32'h55555555, 32);
    repeat (8) begin pt_bit(0); pt_bit(1); end
    idle(14);

    // rejected frames; ch0 must stay disabled
    fr = mk_frame(1, 0, 0, 32'hA5A5A5A5, 32'hFFFFFFFF);
    spi_frame(fr >> 1, FW - 1);
    spi_frame(mk_frame(1, 0, 5, 32'hA5A5A5A5, 32'hFFFFFFFF), FW);
    spi_frame(mk_frame(1, 3'b010, 0, 32'hA5A5A5A5, 32'hFFFFFFFF), FW);
    spi_frame(fr, 0);
    pt_word(32'hA5A5A5A5, 32);
    idle(14);

    // commit in the same cycle as an evaluation: old config decides it
    spi_frame(fr, FW);
    fr_new = mk_frame(1, 0, 0, 32'h4B4B4B4A, 32'hFFFFFFFF);
    spi_open();
    spi_bits(fr_new, FW);
    pt_word(32'hA5A5A5A5 >> 1, 31);
    @(negedge clk) ptclk = 0; ptdat = 1;
    @(negedge clk);
    @(negedge clk) ptclk = 1;
    model_edge(1'b1, cyc);
    @(negedge clk) cs = 1;
    model_cs(fr_new, FW, cyc);
    idle(2);
    pt_bit(0);
    idle(14);

    // reset mid-frame, then a clean frame must commit
    spi_open();
    spi_bits(fr >> 32, 40);
    do_reset();
    spi_close(fr, 0);
    spi_frame(fr, FW);
    pt_word(32'hA5A5A5A5, 32);
    idle(4);
    // reset while that pulse is active
    do_reset();
    idle(14);

    // randomized phase
    for (int c = 0; c < NUM_CH; c++)
      spi_frame(mk_frame(1, 0, 4'(c), $urandom, $urandom & $urandom & $urandom), FW);
    for (int i = 0; i < 200; i++) begin
      pt_bit(1'($urandom));
      if ($urandom_range(0, 29) == 0) begin
        int n;
        case ($urandom_range(0, 3))
          0: n = FW - 5;
          1: n = 0;
          default: n = FW;
        endcase
        spi_frame(mk_frame(1'($urandom), ($urandom_range(0, 3) == 0) ? 3'b001 : 3'b000,
                           4'($urandom_range(0, 5)), $urandom,
                           $urandom & $urandom & $urandom), n);
      end
    end
    idle(30);

    check("hit_queue_drained", 32'(hitq.size()), 32'd0);
    check("err_queue_drained", 32'(errq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
